// File: rtl/nn_pkg.sv
// Shared sizes and loader state encoding for the neural_network frame feeder.
// Defining NN_LOADER_CHECKSUM_EN adds a trailing checksum byte to each frame.
package nn_pkg;

    localparam int DATA_W     = 8;
    localparam int N_INPUTS   = 4;
    localparam int N_NEURONS  = 4;
    localparam int SETTLE_CYC = 2;
    localparam int FRAME_LEN  = N_INPUTS + N_NEURONS * (N_INPUTS + 2);

`ifdef NN_LOADER_CHECKSUM_EN
    localparam int RX_LEN = FRAME_LEN + 1;
`else
    localparam int RX_LEN = FRAME_LEN;
`endif

    localparam int IDX_W  = $clog2(FRAME_LEN + 1);
    localparam int ADDR_W = $clog2(FRAME_LEN);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CHECK,
        STREAM,
        COMMIT,
        SETTLE
    } nn_ldr_state_t;

endpackage

// File: rtl/nn_frame_buffer.sv
// Frame storage: one write port for the accept path, one async read port
// for the replay index. Storage is deliberately left without reset.
module nn_frame_buffer
    import nn_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [FRAME_LEN];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/nn_frame_loader.sv
// Buffers one inference frame from a byte stream, then replays it gap-free
// to neural_network with its changes strobes. NN_LOADER_CHECKSUM_EN: checksum.
module nn_frame_loader
    import nn_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_s_valid,
    input  logic [DATA_W-1:0] i_s_data,
    output logic              o_s_ready,
    output logic [DATA_W-1:0] o_nn_data_in,
    output logic              o_nn_changes,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err
);

`ifdef NN_LOADER_CHECKSUM_EN
    localparam nn_ldr_state_t FILL_EXIT = CHECK;
`else
    localparam nn_ldr_state_t FILL_EXIT = STREAM;
`endif

    nn_ldr_state_t     r_state;
    nn_ldr_state_t     w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_rd;
    logic [SET_W-1:0]  r_settle;
    logic [DATA_W-1:0] r_data;
    logic              r_changes;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_nxt_data;
    logic              w_nxt_changes;
    logic              w_nxt_done;
    logic              w_nxt_err;
    logic              w_rx_state;
    logic              w_accept;
    logic              w_last;
    logic              w_we;
`ifdef NN_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    assign w_rx_state   = (r_state == IDLE) || (r_state == FILL);
    assign o_s_ready    = !i_reset && w_rx_state;
    assign o_busy       = !w_rx_state;
    assign w_accept     = i_s_valid && o_s_ready;
    assign w_last       = (r_idx == IDX_W'(RX_LEN - 1));
    // the trailing checksum byte lands past the end and is never stored
    assign w_we         = w_accept && (r_idx < IDX_W'(FRAME_LEN));
    assign o_nn_data_in = r_data;
    assign o_nn_changes = r_changes;
    assign o_frame_done = r_done;
    assign o_err        = r_err;

    nn_frame_buffer u_buf (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (ADDR_W'(r_idx)),
        .i_wdata (i_s_data),
        .i_raddr (ADDR_W'(r_rd)),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_nxt_data    = r_data;
        w_nxt_changes = 1'b0;
        w_nxt_done    = 1'b0;
        w_nxt_err     = 1'b0;
        unique case (r_state)
            IDLE, FILL: begin
                if (w_accept) begin
                    w_next = w_last ? FILL_EXIT : FILL;
                end
            end
            CHECK: begin
`ifdef NN_LOADER_CHECKSUM_EN
                if (r_sum == '0) begin
                    w_next = STREAM;
                end else begin
                    w_next    = IDLE;
                    w_nxt_err = 1'b1;
                end
`else
                w_next = IDLE;
`endif
            end
            STREAM: begin
                w_nxt_data    = w_rdata;
                w_nxt_changes = (r_rd == IDX_W'(N_INPUTS - 1));
                if (r_rd == IDX_W'(FRAME_LEN - 1)) begin
                    w_next = COMMIT;
                end
            end
            COMMIT: begin
                w_nxt_changes = 1'b1;
                w_next        = SETTLE;
            end
            SETTLE: begin
                // one extra SETTLE cycle keeps s_ready low while frame_done shows
                w_nxt_done = (r_settle == SET_W'(SETTLE_CYC - 1));
                if (r_settle == SET_W'(SETTLE_CYC)) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx     <= '0;
            r_rd      <= '0;
            r_settle  <= '0;
            r_data    <= '0;
            r_changes <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef NN_LOADER_CHECKSUM_EN
            r_sum     <= '0;
`endif
        end else begin
            r_data    <= w_nxt_data;
            r_changes <= w_nxt_changes;
            r_done    <= w_nxt_done;
            r_err     <= w_nxt_err;
            r_rd      <= (r_state == STREAM) ? r_rd + 1'b1 : '0;
            r_settle  <= (r_state == SETTLE) ? r_settle + 1'b1 : '0;
            if (w_next == IDLE) begin
                r_idx <= '0;
            end else if (w_accept && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
`ifdef NN_LOADER_CHECKSUM_EN
            if (w_next == IDLE) begin
                r_sum <= '0;
            end else if (w_accept) begin
                r_sum <= r_sum + i_s_data;
            end
`endif
        end
    end

endmodule

// File: tb/tb_nn_frame_loader.sv
// Scoreboard bench for nn_frame_loader: frame-level reference model pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_nn_frame_loader;
    import nn_pkg::*;

    typedef logic [DATA_W-1:0] bq_t[$];
    typedef struct {
        int                edge_no;
        logic [DATA_W-1:0] data;
        bit                chg;
        bit                done;
        bit                err;
    } exp_t;

`ifdef NN_LOADER_CHECKSUM_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int POST = LAT + FRAME_LEN + SETTLE_CYC;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [DATA_W-1:0] nn_data;
    logic              nn_chg;
    logic              busy;
    logic              done;
    logic              err;

    int                edge_n   = 0;
    int                n_checks = 0;
    int                n_fail   = 0;
    bit                mon_en   = 1'b0;
    exp_t              exp_q[$];
    logic [DATA_W-1:0] last_data = '0;

    nn_frame_loader u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_s_valid    (s_valid),
        .i_s_data     (s_data),
        .o_s_ready    (s_ready),
        .o_nn_data_in (nn_data),
        .o_nn_changes (nn_chg),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, edge_n);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].edge_no < edge_n) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_event: expected at edge %0d, now %0d",
                         exp_q[0].edge_no, edge_n);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].edge_no == edge_n) begin
                e = exp_q.pop_front();
                check("nn_data_in", nn_data, e.data);
                check("nn_changes", nn_chg, e.chg);
                check("frame_done", done, e.done);
                check("err", err, e.err);
            end else begin
                check("quiet_changes", nn_chg, 0);
                check("quiet_done", done, 0);
                check("quiet_err", err, 0);
            end
        end
    end

    function automatic bq_t spec_frame();
        bq_t f;
        f = '{8'd10, 8'd9, 8'd8, 8'd7};
        for (int n = 0; n < 3; n++) begin
            f.push_back(8'd0); f.push_back(8'd5); f.push_back(8'd4);
            f.push_back(8'd3); f.push_back(8'd2); f.push_back(8'd1);
        end
        f.push_back(8'd0);
        for (int i = 0; i < 5; i++) f.push_back(8'd1);
        return f;
    endfunction

    function automatic bq_t rand_frame();
        bq_t f;
        for (int i = 0; i < FRAME_LEN; i++)
            f.push_back(DATA_W'($urandom_range(0, 255)));
        return f;
    endfunction

    function automatic logic [DATA_W-1:0] cs_byte(input bq_t f, input int delta);
        logic [DATA_W-1:0] s;
        s = '0;
        foreach (f[i]) s = s + f[i];
        return DATA_W'(0 - int'(s) + delta);
    endfunction

    // Reference: frame bytes come out in order LAT edges after the last
    // accept, strobe on the last input, commit strobe, then settle + done.
    task automatic push_frame(input bq_t f, input int t);
        for (int k = 0; k < FRAME_LEN; k++)
            exp_q.push_back('{t + LAT + k, f[k], k == N_INPUTS - 1, 1'b0, 1'b0});
        exp_q.push_back('{t + LAT + FRAME_LEN, f[FRAME_LEN-1], 1'b1, 1'b0, 1'b0});
        for (int s = 1; s <= SETTLE_CYC; s++)
            exp_q.push_back('{t + LAT + FRAME_LEN + s, f[FRAME_LEN-1],
                              1'b0, s == SETTLE_CYC, 1'b0});
        last_data = f[FRAME_LEN-1];
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [DATA_W-1:0] b, output int acc_edge);
        int   n;
        logic rdy;
        s_valid = 1'b1;
        s_data  = b;
        n       = 0;
        forever begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", n, 0);
                break;
            end
        end
        acc_edge = edge_n;
        s_valid  = 1'b0;
    endtask

    task automatic send_all(input bq_t f, input bit gaps, output int t);
        for (int i = 0; i < f.size(); i++) begin
            if (gaps && i > 0) idle($urandom_range(1, 5));
            send_byte(f[i], t);
        end
    endtask

    task automatic send_frame(input bq_t f, input bit gaps, input bit hold);
        bq_t tx;
        int  t;
        tx = f;
`ifdef NN_LOADER_CHECKSUM_EN
        tx.push_back(cs_byte(f, 0));
`endif
        send_all(tx, gaps, t);
        push_frame(f, t);
        if (hold) begin
            s_valid = 1'b1;
            s_data  = 8'hEE;
        end
        for (int c = 1; c <= POST; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("ready_low", s_ready, 0);
        end
        s_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_rise", s_ready, 1);
        @(posedge clk);
        #1;
    endtask

`ifdef NN_LOADER_CHECKSUM_EN
    task automatic send_bad(input bq_t f);
        bq_t tx;
        int  t;
        tx = f;
        tx.push_back(cs_byte(f, 1));
        send_all(tx, 1'b0, t);
        exp_q.push_back('{t + 1, last_data, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        @(negedge clk);
        check("ready_after_err", s_ready, 1);
        @(posedge clk);
        #1;
        idle(40);
    endtask
`endif

    task automatic reset_mid_stream(input bq_t f);
        bq_t tx;
        int  t;
        tx = f;
`ifdef NN_LOADER_CHECKSUM_EN
        tx.push_back(cs_byte(f, 0));
`endif
        send_all(tx, 1'b0, t);
        push_frame(f, t);
        do @(negedge clk); while (edge_n < t + LAT + 9);
        #2;
        exp_q.delete();
        last_data = '0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #2;
        check("rst_data", nn_data, 0);
        check("rst_changes", nn_chg, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", s_ready, 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", s_ready, 1);
        @(posedge clk);
        #1;
        idle(40);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t a;
        bq_t b;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", s_ready, 0);
        check("reset_data", nn_data, 0);
        check("reset_changes", nn_chg, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        #1;
        check("ready_first_cycle", s_ready, 1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        send_frame(spec_frame(), 1'b0, 1'b0);
        send_frame(spec_frame(), 1'b1, 1'b0);
        send_frame(rand_frame(), 1'b0, 1'b1);
        reset_mid_stream(rand_frame());
        send_frame(rand_frame(), 1'b1, 1'b0);

        a = rand_frame();
        b = rand_frame();
        b[0] = a[0] ^ 8'h5A;
        send_frame(a, 1'b0, 1'b0);
        send_frame(b, 1'b0, 1'b0);

`ifdef NN_LOADER_CHECKSUM_EN
        send_bad(spec_frame());
        send_frame(spec_frame(), 1'b0, 1'b0);
`endif

        for (int i = 0; i < 3; i++)
            send_frame(rand_frame(), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nn_frame_loader.md
# nn_frame_loader

Upstream feeder for `neural_network`. Accepts one inference frame over a byte-wide valid/ready stream at any rate and buffers it completely. It then replays the frame contiguously, one byte per clock, on `data_in`-compatible outputs. It generates the two `changes` strobes the network expects: one with the last input byte and one after the last parameter byte.

## Interface
- `DATA_W`, 8, byte width of stream and network input.
- `N_INPUTS`, 4, network inputs per frame (x3..x0).
- `N_NEURONS`, 4, neurons; each takes `N_INPUTS+2` bytes (th, b, w(n-1)..w0).
- `SETTLE_CYC`, 2, idle cycles after the commit strobe before `frame_done`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `s_valid`  in  1  upstream byte valid.
- `s_data`  in  DATA_W  upstream byte.
- `s_ready`  out  1  loader can accept a byte.
- `nn_data_in`  out  DATA_W  to `neural_network.data_in`.
- `nn_changes`  out  1  to `neural_network.changes`.
- `busy`  out  1  high in any state other than IDLE/FILL.
- `frame_done`  out  1  one-cycle pulse when a frame has been delivered.
- `err`  out  1  one-cycle pulse when a frame is rejected (checksum build only).

## Operation
- FRAME_LEN = N_INPUTS + N_NEURONS*(N_INPUTS+2), which is 28 at defaults. Byte order is stream order: x3, x2, x1, x0, th3, b3, w33..w30, …, th0, b0, w03..w00. The block never reorders bytes.
- FSM: IDLE → FILL → STREAM → COMMIT → SETTLE → IDLE.
  - IDLE/FILL: `s_ready`=1. A byte is accepted when `s_valid && s_ready` and written to `buf[idx]`, then `idx` increments. The first accept moves IDLE→FILL. Accepting byte FRAME_LEN-1 moves to STREAM (or CHECK, see Configuration).
  - STREAM: `s_ready`=0. `nn_data_in` is driven with `buf[k]` for k = 0..FRAME_LEN-1 on consecutive cycles with no gaps. `nn_changes`=1 only while k = N_INPUTS-1 (x0).
  - COMMIT: one cycle. `nn_changes`=1 and `nn_data_in` holds `buf[FRAME_LEN-1]`.
  - SETTLE: SETTLE_CYC cycles with `nn_changes`=0 and `nn_data_in` held. On the last SETTLE cycle `frame_done`=1, then the FSM returns to IDLE.
- `nn_data_in` and `nn_changes` are registered outputs.
- `idx` width is clog2(FRAME_LEN+1). The counter never wraps: it is cleared on entry to IDLE.
- `s_valid` is ignored whenever `s_ready`=0. Upstream must hold the byte until it is accepted.
- Reset values: `s_ready`=0 during reset and 1 in the first cycle after; `nn_data_in`=0, `nn_changes`=0, `busy`=0, `frame_done`=0, `err`=0; FSM=IDLE; `idx`=0. Buffer contents are don't-care.
- Reset in any state aborts the frame immediately. No further `nn_changes` pulse is issued.

## Timing
- Let t be the edge that accepts the last byte. After edge t+1+k, `nn_data_in`=`buf[k]`.
- After edge t+1+(N_INPUTS-1), `nn_changes`=1 for exactly one cycle.
- After edge t+1+FRAME_LEN, `nn_changes`=1 for exactly one cycle (COMMIT).
- `frame_done` is high after edge t+1+FRAME_LEN+SETTLE_CYC. `s_ready` rises one edge later.
- Minimum frame period at full input rate: 2*FRAME_LEN + SETTLE_CYC + 2 cycles.

## Configuration
- `NN_LOADER_CHECKSUM_EN` defined:
  - The frame carries one extra trailing byte, making FRAME_LEN+1 bytes.
  - FSM inserts a one-cycle CHECK state after FILL. The check passes if the 8-bit sum of all received bytes, mod 2^8, is 0.
  - Pass → STREAM.
  - Fail → `err` pulses for one cycle, nothing is streamed, and the FSM returns to IDLE. `nn_changes` stays 0 and `nn_data_in` is unchanged. `frame_done` does not pulse.
  - The checksum byte is never streamed, and every Timing value shifts by +1 cycle.
- Undefined: no CHECK state, frame is exactly FRAME_LEN bytes, and `err` is tied 0.

## Structure
- Shared package `nn_pkg` holds:
  - `N_INPUTS`, `N_NEURONS`, `DATA_W`, derived `FRAME_LEN`;
  - the state enum `nn_ldr_state_t` (IDLE, FILL, CHECK, STREAM, COMMIT, SETTLE).
- Sub-module `nn_frame_buffer`: a FRAME_LEN×DATA_W register file with one write port (accept path) and one read port (stream index). It has no reset on its storage.

## Test plan
- Single frame at full rate, bytes 10,9,8,7 then (0,5,4,3,2,1)×3 and 0,1,1,1,1,1 → `nn_data_in` sequence matches in order with no gaps; `nn_changes` is high only with byte 7 and in the cycle after the final 1; `frame_done` is high 31 cycles after the last accept.
- Same frame with `s_valid` deasserted randomly for 1–5 cycles between bytes → output stream is identical and contiguous; the first output byte appears exactly 1 cycle after the last accept.
- `s_valid` held high during STREAM/SETTLE → no byte is accepted (`s_ready`=0), and the next frame starts cleanly after `frame_done`.
- Reset asserted mid-STREAM at k=10 → next cycle all outputs are 0 and FSM=IDLE; no second `nn_changes`; a following frame is delivered correctly.
- Checksum build: good trailing byte (256 − sum) → normal delivery. Trailing byte off by 1 → `err` pulses one cycle 1 edge after the last accept, `nn_changes` never rises, and `s_ready`=1 on the next cycle.
- Two back-to-back frames with different x values → the second frame streams only after `frame_done` of the first, and neither frame's bytes appear in the other.
